// File: rtl/tx_serial.sv
// tx_serial: bit-serial transmitter for a fixed message held in an internal ROM.
//
// The message is NUM_WORDS words of DATA_WIDTH bits taken from INIT. It is sent
// LSB-first, starting with word 0. Bits are offered with a valid/ready handshake,
// and tx_finish is raised once the whole message has been delivered.
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   rx_ready   in   receiver can accept a bit this cycle
//   tx_data    out  current serial bit; 0 whenever tx_valid=0
//   tx_valid   out  tx_data holds a bit offered to the receiver
//   tx_finish  out  whole message delivered; sticky until reset
//
// Configuration macro:
//   TX_PARITY_EN  when defined, an even-parity bit (^word) follows the last
//                 data bit of every word, using the same handshake.

module tx_serial #(
    parameter int                              DATA_WIDTH = 8,
    parameter int                              NUM_WORDS  = 4,
    parameter logic [NUM_WORDS*DATA_WIDTH-1:0] INIT       = 32'h0FF03CA5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_ready,
    output logic tx_data,
    output logic tx_valid,
    output logic tx_finish
);

`ifdef TX_PARITY_EN
    localparam int BITS_PER_WORD = DATA_WIDTH + 1;
`else
    localparam int BITS_PER_WORD = DATA_WIDTH;
`endif

    // Counters need at least one bit even when the range collapses to a single value.
    localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_WORD - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   word_q, word_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            data_q, data_d;
    logic            valid_q, valid_d;
    logic            finish_q, finish_d;

    // Serial bit at (word w, position b). With parity enabled, position
    // LAST_BIT is the parity slot rather than a data bit.
    function automatic logic bit_value(input logic [WW-1:0] w, input logic [BW-1:0] b);
        logic [NUM_WORDS*DATA_WIDTH-1:0] img;
        logic [DATA_WIDTH-1:0]           word;
        logic [DATA_WIDTH-1:0]           sh;
        img  = INIT >> (int'(w) * DATA_WIDTH);
        word = img[DATA_WIDTH-1:0];
        sh   = word >> b;
`ifdef TX_PARITY_EN
        if (b == LAST_BIT) begin
            return ^word;
        end
`endif
        return sh[0];
    endfunction

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        bit_d    = bit_q;
        data_d   = data_q;
        valid_d  = valid_q;
        finish_d = finish_q;

        case (state_q)
            IDLE: begin
                if (rx_ready) begin
                    state_d = SEND;
                    word_d  = '0;
                    bit_d   = '0;
                    data_d  = bit_value('0, '0);
                    valid_d = 1'b1;
                end
            end

            SEND: begin
                // tx_valid is always 1 here, so rx_ready alone marks a transfer.
                if (rx_ready) begin
                    if (bit_q == LAST_BIT) begin
                        if (word_q == LAST_WORD) begin
                            state_d  = DONE;
                            data_d   = 1'b0;
                            valid_d  = 1'b0;
                            finish_d = 1'b1;
                        end else begin
                            word_d = word_q + 1'b1;
                            bit_d  = '0;
                            data_d = bit_value(word_q + 1'b1, '0);
                        end
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        data_d = bit_value(word_q, bit_q + 1'b1);
                    end
                end
            end

            DONE: begin
                // Absorbing: everything holds until reset.
            end

            default: begin
                state_d  = IDLE;
                data_d   = 1'b0;
                valid_d  = 1'b0;
                finish_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            word_q   <= '0;
            bit_q    <= '0;
            data_q   <= 1'b0;
            valid_q  <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            finish_q <= finish_d;
        end
    end

    assign tx_data   = data_q;
    assign tx_valid  = valid_q;
    assign tx_finish = finish_q;

endmodule

// File: tb/tb_tx_serial.sv
// Testbench for tx_serial: the expected bit stream is derived from the message
// image and queued; a negedge monitor pops and compares on every transfer.

`timescale 1ns/1ps

module tb_tx_serial;

    localparam int          DW  = 8;
    localparam int          NW  = 4;
    localparam logic [31:0] IMG = 32'h0FF03CA5;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic rx_ready = 1'b0;
    logic tx_data;
    logic tx_valid;
    logic tx_finish;

    tx_serial #(
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .INIT       (IMG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_finish (tx_finish)
    );

    always #5 clk = ~clk;

    int   tests      = 0;
    int   fails      = 0;
    bit   exp_q[$];
    bit   mon_en     = 1'b0;
    bit   expect_fin = 1'b0;
    bit   prev_stall = 1'b0;
    logic prev_data  = 1'b0;
    int   xfers      = 0;
    bit   exp_bit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference stream: words in order, LSB first, optional even parity per word.
    function automatic void load_expected();
        logic [31:0]   img;
        logic [DW-1:0] w;
        img = IMG;
        exp_q.delete();
        for (int k = 0; k < NW; k++) begin
            w = img[k*DW +: DW];
            for (int b = 0; b < DW; b++) exp_q.push_back(w[b]);
`ifdef TX_PARITY_EN
            exp_q.push_back(^w);
`endif
        end
        xfers      = 0;
        expect_fin = 1'b0;
        prev_stall = 1'b0;
    endfunction

    // Monitor: inputs change at posedge+1, so at negedge (valid && ready)
    // means a transfer happens on the coming rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_valid !== 1'b1) check("idle_data_zero", {31'b0, tx_data}, 0);
            check("valid_finish_exclusive", {31'b0, tx_valid & tx_finish}, 0);
            if (prev_stall) begin
                check("stall_valid", {31'b0, tx_valid}, 1);
                check("stall_data", {31'b0, tx_data}, {31'b0, prev_data});
            end
            if (expect_fin) begin
                check("finish_set", {31'b0, tx_finish}, 1);
                check("valid_clear_at_finish", {31'b0, tx_valid}, 0);
                expect_fin = 1'b0;
            end
            if (exp_q.size() > 0) check("finish_early", {31'b0, tx_finish}, 0);
            if (tx_valid === 1'b1 && rx_ready === 1'b1) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    check("no_transfer_after_msg", {31'b0, tx_valid}, 0);
                end else begin
                    exp_bit = exp_q.pop_front();
                    check($sformatf("bit%0d", xfers - 1), {31'b0, tx_data}, {31'b0, exp_bit});
                    if (exp_q.size() == 0) expect_fin = 1'b1;
                end
            end
            prev_stall = (tx_valid === 1'b1) && (rx_ready === 1'b0);
            prev_data  = tx_data;
        end
    end

    task automatic do_reset();
        mon_en   = 1'b0;
        rx_ready = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_valid", {31'b0, tx_valid}, 0);
        check("rst_async_finish", {31'b0, tx_finish}, 0);
        check("rst_async_data", {31'b0, tx_data}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        expect_fin = 1'b0;
        prev_stall = 1'b0;
    endtask

    // mode 0: ready always high; 1: random ready; 2: 3-cycle stall after 5th transfer.
    task automatic run_msg(input int mode);
        int cyc     = 0;
        bit stalled = 1'b0;
        mon_en = 1'b1;
        while (!(exp_q.size() == 0 && tx_finish === 1'b1) && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mode == 0 && cyc == 2) check("first_bit_latency", {31'b0, tx_valid}, 1);
            case (mode)
                1: rx_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (xfers == 5 && !stalled) begin
                        stalled = 1'b1;
                        check("stall_entry_bit5", {31'b0, tx_data}, 1);
                        rx_ready = 1'b0;
                        repeat (3) begin
                            @(posedge clk);
                            #1;
                            check("stall_hold_valid", {31'b0, tx_valid}, 1);
                            check("stall_hold_bit5", {31'b0, tx_data}, 1);
                        end
                    end
                    rx_ready = 1'b1;
                end
                default: rx_ready = 1'b1;
            endcase
        end
        check("msg_complete", {31'b0, (exp_q.size() == 0) && (tx_finish === 1'b1)}, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset hold, then receiver not ready: outputs stay quiet.
        do_reset();
        mon_en = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("idle_valid", {31'b0, tx_valid}, 0);
            check("idle_finish", {31'b0, tx_finish}, 0);
            check("idle_data", {31'b0, tx_data}, 0);
        end

        // Full message with ready held high.
        load_expected();
        run_msg(0);

        // DONE ignores rx_ready.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            rx_ready = 1'(i % 2);
            check("done_finish_sticky", {31'b0, tx_finish}, 1);
            check("done_valid_low", {31'b0, tx_valid}, 0);
        end

        // Stall after the 5th transfer.
        do_reset();
        load_expected();
        run_msg(2);

        // Random back-pressure.
        repeat (3) begin
            do_reset();
            load_expected();
            run_msg(1);
        end

        // Reset in the middle of word 2, restart with ready high.
        do_reset();
        load_expected();
        mon_en = 1'b1;
        for (int c = 0; c < 200 && xfers < 20; c++) begin
            @(posedge clk);
            #1 rx_ready = 1'b1;
        end
        check("reached_word2", {31'b0, xfers >= 20}, 1);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_valid", {31'b0, tx_valid}, 0);
        check("midrst_data", {31'b0, tx_data}, 0);
        check("midrst_finish", {31'b0, tx_finish}, 0);
        repeat (2) @(posedge clk);
        load_expected();
        @(negedge clk);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        run_msg(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
